// File: rtl/video_linebuf_sched.sv
// rtl/video_linebuf_sched.sv - ping-pong line buffer scheduler between PPU writes and line-doubled VGA reads
// Optional build macro: VIDEO_LINEBUF_STATS_EN adds saturating underrun_cnt/overrun_cnt outputs.
module video_linebuf_sched #(
  parameter int WIDTH  = 256,
  parameter int AW     = 8,
  parameter int REPEAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          pix_valid,
  input  logic          line_end,
  input  logic          rd_line_start,
  input  logic          rd_pix,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic          rd_bank,
  output logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [1:0]    state,
  output logic          underrun,
  output logic          overrun
`ifdef VIDEO_LINEBUF_STATS_EN
  ,
  output logic [15:0]   underrun_cnt,
  output logic [15:0]   overrun_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [AW:0]   WIDTH_W   = (AW+1)'(WIDTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH - 1);
  localparam logic [1:0]    REPEAT_W  = 2'(REPEAT);

  state_t      st;
  logic [1:0]  full;
  logic [AW:0] wr_cnt;
  logic [1:0]  rep_cnt;

  logic        le_act;
  logic        rls_run;
  logic        rep_done;
  logic        swap;
  logic        ovr_evt;
  logic        unr_evt;
  logic [1:0]  full_set;
  logic [1:0]  full_clr;
  logic [1:0]  full_nxt;

  assign state = st;

  // Event decode against the flags registered at the start of the cycle; resync masks everything
  always_comb begin
    le_act   = line_end && (st != IDLE) && !frame_start;
    rls_run  = rd_line_start && (st == RUN) && !frame_start;
    rep_done = (rep_cnt == REPEAT_W);
    swap     = rls_run && rep_done && full[~rd_bank];
    unr_evt  = rls_run && rep_done && !full[~rd_bank];
    ovr_evt  = le_act && full[~wr_bank];
    full_set = le_act ? (2'b01 << wr_bank) : 2'b00;
    full_clr = swap ? (2'b01 << rd_bank) : 2'b00;
    // A release and a fill of the same bank in one cycle leaves it full
    full_nxt = (full & ~full_clr) | full_set;
  end

  // Scheduler FSM: write-side bookkeeping, read-side sequencing and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      full     <= 2'b00;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_cnt   <= '0;
      rep_cnt  <= 2'd0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      rd_valid <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (frame_start) begin
        st       <= PRIME;
        full     <= 2'b00;
        wr_bank  <= 1'b0;
        rd_bank  <= 1'b0;
        wr_cnt   <= '0;
        rep_cnt  <= 2'd0;
        rd_valid <= 1'b0;
      end else if (st != IDLE) begin
        // Pixels beyond the line width are dropped without a write strobe
        if (pix_valid && (wr_cnt < WIDTH_W)) begin
          wr_en   <= 1'b1;
          wr_addr <= wr_cnt[AW-1:0];
          wr_cnt  <= wr_cnt + 1'b1;
        end
        if (le_act) begin
          wr_cnt <= '0;
          if (!full[~wr_bank]) begin
            wr_bank <= ~wr_bank;
          end else begin
            overrun <= 1'b1;
          end
        end
        full <= full_nxt;

        if (st == PRIME) begin
          rd_valid <= 1'b0;
          if (rd_line_start && full[0]) begin
            st       <= RUN;
            rd_bank  <= 1'b0;
            rep_cnt  <= 2'd1;
            rd_addr  <= '0;
            rd_valid <= 1'b1;
          end
        end else begin
          rd_valid <= 1'b1;
          if (rls_run) begin
            rd_addr <= '0;
            if (!rep_done) begin
              rep_cnt <= rep_cnt + 2'd1;
            end else if (swap) begin
              rd_bank <= ~rd_bank;
              rep_cnt <= 2'd1;
            end else begin
              underrun <= 1'b1;
            end
          end else if (rd_pix && (rd_addr != LAST_ADDR)) begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
      end
    end
  end

`ifdef VIDEO_LINEBUF_STATS_EN
  // Saturating event counters, cleared on reset and at every frame start
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      underrun_cnt <= 16'd0;
      overrun_cnt  <= 16'd0;
    end else begin
      if (unr_evt && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
      if (ovr_evt && (overrun_cnt != 16'hFFFF)) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_video_linebuf_sched.sv
// tb/tb_video_linebuf_sched.sv - scoreboard bench for video_linebuf_sched
module tb_video_linebuf_sched;

  typedef struct packed {
    logic [1:0]  st;
    logic        wb;
    logic        rb;
    logic [7:0]  ra;
    logic        rv;
    logic        un;
    logic        ov;
    logic [15:0] uc;
    logic [15:0] oc;
  } snap_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic       line_end = 1'b0;
  logic       rd_line_start = 1'b0;
  logic       rd_pix = 1'b0;
  logic       wr_en;
  logic       wr_bank;
  logic [7:0] wr_addr;
  logic       rd_bank;
  logic [7:0] rd_addr;
  logic       rd_valid;
  logic [1:0] state;
  logic       underrun;
  logic       overrun;
`ifdef VIDEO_LINEBUF_STATS_EN
  logic [15:0] underrun_cnt;
  logic [15:0] overrun_cnt;
`endif

  logic [8:0] wr_q[$];
  snap_t      snap_q[$];
  string      name_q[$];
  logic       done = 1'b0;
  int         checks = 0;
  int         errors = 0;

  video_linebuf_sched #(.WIDTH(256), .AW(8), .REPEAT(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .line_end      (line_end),
    .rd_line_start (rd_line_start),
    .rd_pix        (rd_pix),
    .wr_en         (wr_en),
    .wr_bank       (wr_bank),
    .wr_addr       (wr_addr),
    .rd_bank       (rd_bank),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .state         (state),
    .underrun      (underrun),
    .overrun       (overrun)
`ifdef VIDEO_LINEBUF_STATS_EN
    ,
    .underrun_cnt  (underrun_cnt),
    .overrun_cnt   (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    frame_start   = 1'b0;
    pix_valid     = 1'b0;
    line_end      = 1'b0;
    rd_line_start = 1'b0;
    rd_pix        = 1'b0;
  endtask

  task automatic expect_snap(input string n, input int st, input int wb, input int rb, input int ra,
                             input int rv, input int un, input int ov, input int uc, input int oc);
    snap_t s;
    s.st = 2'(st);
    s.wb = 1'(wb);
    s.rb = 1'(rb);
    s.ra = 8'(ra);
    s.rv = 1'(rv);
    s.un = 1'(un);
    s.ov = 1'(ov);
`ifdef VIDEO_LINEBUF_STATS_EN
    s.uc = 16'(uc);
    s.oc = 16'(oc);
`else
    s.uc = 16'd0;
    s.oc = 16'd0;
`endif
    snap_q.push_back(s);
    name_q.push_back(n);
  endtask

  task automatic write_line(input int n, input logic bank);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      if (i < 256) wr_q.push_back({bank, 8'(i)});
      tick();
    end
    line_end = 1'b1;
    tick();
  endtask

  task automatic rd_start();
    rd_line_start = 1'b1;
    tick();
  endtask

  task automatic pix_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_pix = 1'b1;
      tick();
    end
  endtask

  // Monitor: pops expected writes on every wr_en and expected status snapshots as they are queued
  always @(negedge clk) begin
    logic [8:0] ew;
    snap_t      es;
    snap_t      as;
    string      nm;
    if (wr_en === 1'b1) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got bank %0d addr %0d, none expected", wr_bank, wr_addr);
      end else begin
        ew = wr_q.pop_front();
        if ({wr_bank, wr_addr} !== ew) begin
          errors++;
          $display("FAIL wr_pixel: got bank %0d addr %0d, want bank %0d addr %0d",
                   wr_bank, wr_addr, ew[8], ew[7:0]);
        end
      end
    end
    while (snap_q.size() > 0) begin
      es = snap_q.pop_front();
      nm = name_q.pop_front();
      as.st = state;
      as.wb = wr_bank;
      as.rb = rd_bank;
      as.ra = rd_addr;
      as.rv = rd_valid;
      as.un = underrun;
      as.ov = overrun;
`ifdef VIDEO_LINEBUF_STATS_EN
      as.uc = underrun_cnt;
      as.oc = overrun_cnt;
`else
      as.uc = 16'd0;
      as.oc = 16'd0;
`endif
      checks++;
      if (as !== es) begin
        errors++;
        $display("FAIL %s: got st=%0d wb=%0d rb=%0d ra=%0d rv=%0d un=%0d ov=%0d uc=%0d oc=%0d want st=%0d wb=%0d rb=%0d ra=%0d rv=%0d un=%0d ov=%0d uc=%0d oc=%0d",
                 nm, as.st, as.wb, as.rb, as.ra, as.rv, as.un, as.ov, as.uc, as.oc,
                 es.st, es.wb, es.rb, es.ra, es.rv, es.un, es.ov, es.uc, es.oc);
      end
    end
    if (done) begin
      checks++;
      if (wr_q.size() != 0) begin
        errors++;
        $display("FAIL wr_missing: got %0d writes outstanding, want 0", wr_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, want finish");
    $fatal(1);
  end

  initial begin
    // reset state and IDLE behaviour
    tick();
    tick();
    expect_snap("rst_init", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    rd_start();
    expect_snap("idle_ignore", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reach RUN with both banks full, then reset
    frame_start = 1'b1;
    tick();
    expect_snap("t1_prime", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    write_line(4, 1'b0);
    expect_snap("t1_le1", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    rd_start();
    expect_snap("t1_run", 2, 1, 0, 0, 1, 0, 0, 0, 0);
    write_line(4, 1'b1);
    expect_snap("t1_full11", 2, 1, 0, 0, 1, 0, 1, 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_snap("t1_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // full line into bank 0, read with address saturation
    frame_start = 1'b1;
    tick();
    expect_snap("t2_prime", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    rd_start();
    expect_snap("t2_prime_empty", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    write_line(256, 1'b0);
    expect_snap("t2_le", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    rd_start();
    expect_snap("t2_run", 2, 1, 0, 0, 1, 0, 0, 0, 0);
    pix_n(254);
    expect_snap("t2_addr254", 2, 1, 0, 254, 1, 0, 0, 0, 0);
    pix_n(2);
    expect_snap("t2_addr_sat", 2, 1, 0, 255, 1, 0, 0, 0, 0);

    // line doubling: rd_bank 0,0,1,1,0,0
    rd_start();
    expect_snap("t3_rd2", 2, 1, 0, 0, 1, 0, 0, 0, 0);
    write_line(4, 1'b1);
    expect_snap("t3_le_ov", 2, 1, 0, 0, 1, 0, 1, 0, 1);
    rd_start();
    expect_snap("t3_rd3", 2, 1, 1, 0, 1, 0, 1, 0, 1);
    rd_start();
    expect_snap("t3_rd4", 2, 1, 1, 0, 1, 0, 1, 0, 1);
    write_line(4, 1'b1);
    expect_snap("t3_le_b1", 2, 0, 1, 0, 1, 0, 1, 0, 1);
    write_line(4, 1'b0);
    expect_snap("t3_le_b0", 2, 0, 1, 0, 1, 0, 1, 0, 2);
    rd_start();
    expect_snap("t3_rd5", 2, 0, 0, 0, 1, 0, 1, 0, 2);
    pix_n(3);
    expect_snap("t3_pix3", 2, 0, 0, 3, 1, 0, 1, 0, 2);
    rd_start();
    expect_snap("t3_rd6", 2, 0, 0, 0, 1, 0, 1, 0, 2);

    // underrun: only one line stored, three VGA lines
    frame_start = 1'b1;
    tick();
    expect_snap("t4_resync", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    write_line(4, 1'b0);
    expect_snap("t4_le", 1, 1, 0, 0, 0, 0, 1, 0, 0);
    rd_start();
    expect_snap("t4_rd1", 2, 1, 0, 0, 1, 0, 1, 0, 0);
    rd_start();
    expect_snap("t4_rd2", 2, 1, 0, 0, 1, 0, 1, 0, 0);
    rd_start();
    expect_snap("t4_under", 2, 1, 0, 0, 1, 1, 1, 1, 0);
    rd_start();
    expect_snap("t4_under2", 2, 1, 0, 0, 1, 1, 1, 2, 0);
    write_line(4, 1'b1);
    expect_snap("t4_le2", 2, 1, 0, 0, 1, 1, 1, 2, 1);
    rd_start();
    expect_snap("t4_swap", 2, 1, 1, 0, 1, 1, 1, 2, 1);

    // overrun: three line_end pulses with no reader
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_snap("t5_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    frame_start = 1'b1;
    tick();
    expect_snap("t5_prime", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    write_line(2, 1'b0);
    expect_snap("t5_le1", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    write_line(2, 1'b1);
    expect_snap("t5_le2", 1, 1, 0, 0, 0, 0, 1, 0, 1);
    write_line(2, 1'b1);
    expect_snap("t5_le3", 1, 1, 0, 0, 0, 0, 1, 0, 2);

    // over-long line is truncated; frame_start beats a coincident line_end
    frame_start = 1'b1;
    tick();
    expect_snap("t6_prime", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    write_line(300, 1'b0);
    expect_snap("t6_le", 1, 1, 0, 0, 0, 0, 1, 0, 0);
    write_line(2, 1'b1);
    expect_snap("t6_le2", 1, 1, 0, 0, 0, 0, 1, 0, 1);
    frame_start = 1'b1;
    line_end    = 1'b1;
    tick();
    expect_snap("t6_fs_le", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    rd_start();
    expect_snap("t6_full_clear", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    write_line(2, 1'b0);
    expect_snap("t6_after", 1, 1, 0, 0, 0, 0, 1, 0, 0);

    done = 1'b1;
    repeat (20) @(posedge clk);
    $display("FAIL monitor_done: got no summary, want summary");
    $fatal(1);
  end

endmodule
